// File: rtl/cla_pkg.sv
// Shared constants for the pipelined CLA add/sub datapath: op encodings and default geometry.
package cla_pkg;
    localparam int CLA_WIDTH = 16;
    localparam int CLA_GROUP = 4;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_ADC    = 2'b10;
    localparam logic [1:0] OP_SATADD = 2'b11;
endpackage

// File: rtl/cla_group.sv
// GROUP-bit first-level lookahead cell: sum bits from a group carry-in, plus group propagate/generate.
module cla_group import cla_pkg::*; #(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] sum_o,
    output logic             p_o,
    output logic             g_o
);
    logic [GROUP-1:0] p, g, c;
    logic             cterm, gterm;

    assign p     = a_i ^ b_i;
    assign g     = a_i & b_i;
    assign p_o   = &p;
    assign sum_o = p ^ c;

    // Each internal carry is a flat sum of products, no ripple between bits.
    always_comb begin
        c     = '0;
        cterm = 1'b0;
        c[0]  = c_i;
        for (int i = 1; i < GROUP; i++) begin
            cterm = c_i;
            for (int m = 0; m < i; m++) cterm = cterm & p[m];
            c[i] = cterm;
            for (int k = 0; k < i; k++) begin
                cterm = g[k];
                for (int m = k + 1; m < i; m++) cterm = cterm & p[m];
                c[i] = c[i] | cterm;
            end
        end
    end

    always_comb begin
        g_o   = 1'b0;
        gterm = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            gterm = g[k];
            for (int m = k + 1; m < GROUP; m++) gterm = gterm & p[m];
            g_o = g_o | gterm;
        end
    end
endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage CLA add/sub with valid/ready flow control and status flags.
// Optional signed saturation for op SATADD is enabled by defining CLA_SAT_EN.
module cla_addsub_pipe import cla_pkg::*; #(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int NG = WIDTH / GROUP;

    logic             s1_valid_q, out_valid_q;
    logic [WIDTH-1:0] a_q, bp_q, bp_d;
    logic             c0_q, c0_d;
    logic             s2_free, s1_adv;
    logic [WIDTH-1:0] raw, sum_d, sum_q;
    logic [NG-1:0]    gp, gg;
    logic [NG:0]      gc;
    logic             lterm, cmsb, cout_d, ovf_d;
    logic             cout_q, ovf_q, zero_q, neg_q;
`ifdef CLA_SAT_EN
    logic             sat_q;
`endif

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s1_adv;

    // Subtraction is a + ~b + 1; only SUB and ADC inject a carry.
    always_comb begin
        bp_d = (op == OP_SUB) ? ~b : b;
        c0_d = 1'b0;
        if (op == OP_SUB)      c0_d = 1'b1;
        else if (op == OP_ADC) c0_d = cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            bp_q       <= '0;
            c0_q       <= 1'b0;
`ifdef CLA_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                bp_q  <= bp_d;
                c0_q  <= c0_d;
`ifdef CLA_SAT_EN
                sat_q <= (op == OP_SATADD);
`endif
            end
        end
    end

    // Group P/G are formed from the prepared operands held in the stage-1 register.
    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i   (a_q[j*GROUP +: GROUP]),
            .b_i   (bp_q[j*GROUP +: GROUP]),
            .c_i   (gc[j]),
            .sum_o (raw[j*GROUP +: GROUP]),
            .p_o   (gp[j]),
            .g_o   (gg[j])
        );
    end

    // Second-level lookahead: every group carry-in is a flat sum of products.
    always_comb begin
        gc    = '0;
        lterm = 1'b0;
        gc[0] = c0_q;
        for (int j = 1; j <= NG; j++) begin
            lterm = c0_q;
            for (int m = 0; m < j; m++) lterm = lterm & gp[m];
            gc[j] = lterm;
            for (int k = 0; k < j; k++) begin
                lterm = gg[k];
                for (int m = k + 1; m < j; m++) lterm = lterm & gp[m];
                gc[j] = gc[j] | lterm;
            end
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        cmsb   = a_q[WIDTH-1] ^ bp_q[WIDTH-1] ^ raw[WIDTH-1];
        cout_d = gc[NG];
        ovf_d  = gc[NG] ^ cmsb;
        sum_d  = raw;
`ifdef CLA_SAT_EN
        if (sat_q && ovf_d)
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= (sum_d == '0);
            neg_q       <= sum_d[WIDTH-1];
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed plus randomized checks of cla_addsub_pipe against an arithmetic reference model.
module tb_cla_addsub_pipe;
    import cla_pkg::*;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready;
    logic         cout, ovf, zero, neg;
    logic [1:0]   op;
    logic [W-1:0] a, b, sum;
    int           checks = 0;
    int           errors = 0;
    res_t         expq[$];

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
        .zero(zero), .neg(neg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        res_t   r;
        longint ux, uy, sx, sy, full, sres;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_SUB: begin full = ux - uy + 65536; sres = sx - sy; end
            OP_ADC: begin full = ux + uy + longint'(ci); sres = sx + sy + longint'(ci); end
            default: begin full = ux + uy; sres = sx + sy; end
        endcase
        r.sum  = W'(full);
        r.cout = full >= 65536;
        r.ovf  = (sres > 32767) || (sres < -32768);
`ifdef CLA_SAT_EN
        if (o == OP_SATADD && r.ovf) r.sum = (sx < 0) ? 16'h8000 : 16'h7FFF;
`endif
        r.zero = (r.sum == 0);
        r.neg  = r.sum[W-1];
        return r;
    endfunction

    // One isolated request with out_ready high; result must appear after the second edge.
    task automatic run1(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez, input logic en);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_flags"}, {cout, ovf, zero, neg}, {ec, eo, ez, en});
    endtask

    // Streams n requests; fixed mode sends ADD k+1 with out_ready low for the first stall cycles.
    task automatic run_stream(input int n, input bit rnd, input int stall);
        int   sent = 0, got = 0, cyc = 0;
        bit   held_v = 1'b0;
        res_t held, cur, e;
        while ((sent < n || got < sent) && cyc < 3000) begin
            @(negedge clk);
            cur = {sum, cout, ovf, zero, neg};
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_stable", cur, held);
            end
            in_valid = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (rnd) begin
                op = 2'($urandom_range(0, 3)); a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                op = OP_ADD; a = W'(sent); b = 16'h0001; cin = 1'b0;
                out_ready = (cyc >= stall);
            end
            #1;
            if (!rnd && cyc == 2) chk("in_ready_drop", in_ready, 0);
            if (in_valid && in_ready) begin
                expq.push_back(model(op, a, b, cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("result_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk(rnd ? "rnd_result" : "stream_result", cur, e);
                    if (!rnd) chk("stream_order", sum, got + 1);
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = cur;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_sent", sent, n);
        chk("stream_drained", got, sent);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_ADD; a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_outs", {sum, cout, ovf, zero, neg}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        run1("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        run1("sub_eq",  OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1, 0, 1, 0);
        run1("sub_brw", OP_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 0, 0, 0, 1);
        run1("adc",     OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, 0);
        run1("add_cin", OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 0, 0, 0, 1);
`ifdef CLA_SAT_EN
        run1("sat_pos", OP_SATADD, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0);
        run1("sat_neg", OP_SATADD, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1, 1, 0, 1);
`else
        run1("sat_pos", OP_SATADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        run1("sat_neg", OP_SATADD, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1, 1, 0, 0);
`endif

        run_stream(4, 1'b0, 3);

        // Fill both stages, then reset asynchronously between edges.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 16'h0010; b = 16'h0001;
        @(negedge clk);
        a = 16'h0020;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_outs", {sum, cout, ovf, zero, neg}, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("arst_rel_in_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        run1("post_rst", OP_ADD, 16'h1234, 16'h0101, 1'b0, 16'h1335, 0, 0, 0, 0);

        run_stream(300, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
